// File: rtl/delivery_ctrl.sv
// delivery_ctrl: colour-delivery sequencer.
// Latches an object colour on start, tracks until the station colour matches,
// bounces at the end of the track up to MAX_LAPS times, then returns home and
// reverses into the dock. Object removal is confirmed by a debounced hall input.
// Optional per-state watchdog enabled by defining DELIVERY_WDOG_EN.
module delivery_ctrl #(
    parameter int COLOR_W  = 2,
    parameter int MAX_LAPS = 2,
    parameter int HALL_DEB = 1000,
    parameter int WDOG_CYC = 2**28
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [COLOR_W-1:0]            object_color,
    input  logic [COLOR_W-1:0]            station_color,
    input  logic                          hall,
    input  logic                          end_of_track,
    input  logic                          uturn_finished,
    input  logic                          brake_finished,
    input  logic                          reverse_finished,
    input  logic                          buzz_finished,
    output logic                          en_tracking,
    output logic                          en_uturn,
    output logic                          en_brake,
    output logic                          en_reverse,
    output logic                          en_buzz,
    output logic                          object_led,
    output logic                          station_led,
    output logic [3:0]                    disp_state,
    output logic [COLOR_W-1:0]            disp_color,
    output logic [$clog2(MAX_LAPS+1)-1:0] lap_cnt,
    output logic                          fault
);

    localparam int LAP_W  = $clog2(MAX_LAPS + 1);
    localparam int DEB_W  = (HALL_DEB > 1) ? $clog2(HALL_DEB) : 1;
    localparam int WDOG_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

    // State encodings double as the display codes.
    typedef enum logic [3:0] {
        S_READY   = 4'h0,
        S_SEND    = 4'h1,
        S_MATCH   = 4'h2,
        S_EOT     = 4'h3,
        S_UTURN   = 4'h4,
        S_RETURN  = 4'h5,
        S_REVERSE = 4'h6,
        S_NOCOLOR = 4'h7,
        S_FAULT   = 4'hF
    } state_t;

    state_t             state, state_n;
    logic [COLOR_W-1:0] color_q, color_n;
    logic [LAP_W-1:0]   lap_q, lap_n;
    logic               returning, returning_n;
    logic               ret_home, ret_home_n;
    logic               buzz_seen, buzz_seen_n;
    logic               brake_seen, brake_seen_n;
    logic [DEB_W-1:0]   deb_cnt, deb_n;
    logic               buzz_ok, brake_ok;

    // Output values decoded from the next state, registered alongside it.
    logic en_tracking_n, en_uturn_n, en_brake_n, en_reverse_n, en_buzz_n;
    logic object_led_n, station_led_n;

`ifdef DELIVERY_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt, wdog_n;
    logic              wdog_counting;
`endif

    assign buzz_ok  = buzz_finished | buzz_seen;
    assign brake_ok = brake_finished | brake_seen;

    // Next-state, bookkeeping and output decode.
    always_comb begin
        state_n       = state;
        color_n       = color_q;
        lap_n         = lap_q;
        returning_n   = returning;
        ret_home_n    = ret_home;
        buzz_seen_n   = buzz_seen;
        brake_seen_n  = brake_seen;
        deb_n         = '0;

        case (state)
            S_READY: begin
                if (start) begin
                    if (object_color == '0) begin
                        state_n = S_NOCOLOR;
                    end else begin
                        state_n     = S_SEND;
                        color_n     = object_color;
                        lap_n       = '0;
                        returning_n = 1'b0;
                        ret_home_n  = 1'b0;
                    end
                end
            end
            S_NOCOLOR: begin
                if (buzz_finished) state_n = S_READY;
            end
            S_SEND: begin
                // A colour match wins over a simultaneous end of track.
                if (station_color == color_q) begin
                    state_n = S_MATCH;
                end else if (end_of_track) begin
                    state_n      = S_EOT;
                    lap_n        = (lap_q == LAP_W'(MAX_LAPS)) ? lap_q : lap_q + LAP_W'(1);
                    buzz_seen_n  = 1'b0;
                    brake_seen_n = 1'b0;
                end
            end
            S_MATCH: begin
                // Count consecutive low hall cycles; any high restarts the run.
                if (!hall) begin
                    if (deb_cnt == DEB_W'(HALL_DEB - 1)) begin
                        state_n     = S_UTURN;
                        returning_n = 1'b1;
                    end else begin
                        deb_n = deb_cnt + DEB_W'(1);
                    end
                end
            end
            S_EOT: begin
                // Buzzer and brake completions may arrive in any order.
                buzz_seen_n  = buzz_ok;
                brake_seen_n = brake_ok;
                if (buzz_ok && brake_ok) begin
                    state_n      = S_UTURN;
                    buzz_seen_n  = 1'b0;
                    brake_seen_n = 1'b0;
                    if (lap_q == LAP_W'(MAX_LAPS)) returning_n = 1'b1;
                end
            end
            S_UTURN: begin
                if (uturn_finished) begin
                    if (ret_home)       state_n = S_REVERSE;
                    else if (returning) state_n = S_RETURN;
                    else                state_n = S_SEND;
                end
            end
            S_RETURN: begin
                if (end_of_track) begin
                    state_n    = S_UTURN;
                    ret_home_n = 1'b1;
                end
            end
            S_REVERSE: begin
                if (reverse_finished) begin
                    state_n     = S_READY;
                    color_n     = '0;
                    lap_n       = '0;
                    returning_n = 1'b0;
                    ret_home_n  = 1'b0;
                end
            end
            S_FAULT: begin
                state_n = S_FAULT;
            end
            default: begin
                state_n = S_READY;
            end
        endcase

`ifdef DELIVERY_WDOG_EN
        // Watchdog overrides any normal transition once the limit is reached.
        wdog_counting = (state == S_SEND) || (state == S_EOT) || (state == S_UTURN) ||
                        (state == S_RETURN) || (state == S_REVERSE);
        if (wdog_counting && (wdog_cnt == WDOG_W'(WDOG_CYC - 1))) state_n = S_FAULT;
        if (state_n != state)  wdog_n = '0;
        else if (wdog_counting) wdog_n = wdog_cnt + WDOG_W'(1);
        else                    wdog_n = wdog_cnt;
`endif

        en_tracking_n = (state_n == S_SEND) || (state_n == S_RETURN);
        en_uturn_n    = (state_n == S_UTURN);
        en_brake_n    = (state_n == S_MATCH) || (state_n == S_EOT);
        en_reverse_n  = (state_n == S_REVERSE);
        en_buzz_n     = (state_n == S_MATCH) || (state_n == S_EOT) ||
                        (state_n == S_NOCOLOR) || (state_n == S_FAULT);
        object_led_n  = (state_n == S_READY) || (state_n == S_NOCOLOR);
        station_led_n = (state_n == S_SEND);
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_READY;
            color_q     <= '0;
            lap_q       <= '0;
            returning   <= 1'b0;
            ret_home    <= 1'b0;
            buzz_seen   <= 1'b0;
            brake_seen  <= 1'b0;
            deb_cnt     <= '0;
            en_tracking <= 1'b0;
            en_uturn    <= 1'b0;
            en_brake    <= 1'b0;
            en_reverse  <= 1'b0;
            en_buzz     <= 1'b0;
            object_led  <= 1'b1;
            station_led <= 1'b0;
        end else begin
            state       <= state_n;
            color_q     <= color_n;
            lap_q       <= lap_n;
            returning   <= returning_n;
            ret_home    <= ret_home_n;
            buzz_seen   <= buzz_seen_n;
            brake_seen  <= brake_seen_n;
            deb_cnt     <= deb_n;
            en_tracking <= en_tracking_n;
            en_uturn    <= en_uturn_n;
            en_brake    <= en_brake_n;
            en_reverse  <= en_reverse_n;
            en_buzz     <= en_buzz_n;
            object_led  <= object_led_n;
            station_led <= station_led_n;
        end
    end

`ifdef DELIVERY_WDOG_EN
    // Watchdog counter and sticky fault flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            wdog_cnt <= wdog_n;
            fault    <= (state_n == S_FAULT);
        end
    end
`else
    assign fault = 1'b0;
`endif

    assign disp_state = state;
    assign disp_color = color_q;
    assign lap_cnt    = lap_q;

endmodule

// File: tb/tb_delivery_ctrl.sv
// Directed bench for delivery_ctrl: reset, match/debounce path, no-colour path,
// lap give-up path, match-vs-end-of-track priority, mid-trip reset, and the
// watchdog when DELIVERY_WDOG_EN is defined.
module tb_delivery_ctrl;

    localparam int TB_DEB  = 16;
    localparam int TB_WDOG = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] object_color;
    logic [1:0] station_color;
    logic       hall;
    logic       end_of_track;
    logic       uturn_finished;
    logic       brake_finished;
    logic       reverse_finished;
    logic       buzz_finished;
    logic       en_tracking, en_uturn, en_brake, en_reverse, en_buzz;
    logic       object_led, station_led;
    logic [3:0] disp_state;
    logic [1:0] disp_color;
    logic [1:0] lap_cnt;
    logic       fault;
    logic [4:0] ens;

    int pass_cnt  = 0;
    int total_cnt = 0;

    assign ens = {en_tracking, en_uturn, en_brake, en_reverse, en_buzz};

    delivery_ctrl #(
        .COLOR_W (2),
        .MAX_LAPS(2),
        .HALL_DEB(TB_DEB),
        .WDOG_CYC(TB_WDOG)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .object_color    (object_color),
        .station_color   (station_color),
        .hall            (hall),
        .end_of_track    (end_of_track),
        .uturn_finished  (uturn_finished),
        .brake_finished  (brake_finished),
        .reverse_finished(reverse_finished),
        .buzz_finished   (buzz_finished),
        .en_tracking     (en_tracking),
        .en_uturn        (en_uturn),
        .en_brake        (en_brake),
        .en_reverse      (en_reverse),
        .en_buzz         (en_buzz),
        .object_led      (object_led),
        .station_led     (station_led),
        .disp_state      (disp_state),
        .disp_color      (disp_color),
        .lap_cnt         (lap_cnt),
        .fault           (fault)
    );

    // Clock and global time bound
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout reached before summary");
        $fatal(1);
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; object_color = 0; station_color = 0; hall = 1;
        end_of_track = 0; uturn_finished = 0; brake_finished = 0;
        reverse_finished = 0; buzz_finished = 0;
    endtask

    // Ens order: {tracking, uturn, brake, reverse, buzz}
    task automatic test_reset();
        rst = 0; idle_inputs();
        tick(); tick();
        total_cnt++; if (disp_state !== 4'h0) $display("FAIL reset_state got %0h want 0", disp_state); else pass_cnt++;
        total_cnt++; if (ens !== 5'b00000) $display("FAIL reset_ens got %b want 00000", ens); else pass_cnt++;
        total_cnt++; if ({object_led, station_led} !== 2'b10) $display("FAIL reset_leds got %b want 10", {object_led, station_led}); else pass_cnt++;
        total_cnt++; if ({disp_color, lap_cnt, fault} !== 5'b0) $display("FAIL reset_color_lap_fault got %b want 00000", {disp_color, lap_cnt, fault}); else pass_cnt++;
        rst = 1; tick();
        total_cnt++; if (disp_state !== 4'h0) $display("FAIL reset_idle_state got %0h want 0", disp_state); else pass_cnt++;
    endtask

    task automatic test_match();
        start = 1; object_color = 2; station_color = 0; tick();
        start = 0; object_color = 0;
        total_cnt++; if (disp_state !== 4'h1) $display("FAIL match_send_state got %0h want 1", disp_state); else pass_cnt++;
        total_cnt++; if (disp_color !== 2'd2) $display("FAIL match_color got %0d want 2", disp_color); else pass_cnt++;
        total_cnt++; if ({ens, object_led, station_led} !== 7'b1000001) $display("FAIL match_send_outs got %b want 1000001", {ens, object_led, station_led}); else pass_cnt++;
        station_color = 1;
        for (int i = 0; i < 10; i++) tick();
        total_cnt++; if (disp_state !== 4'h1) $display("FAIL match_still_send got %0h want 1", disp_state); else pass_cnt++;
        station_color = 2; tick();
        total_cnt++; if (disp_state !== 4'h2) $display("FAIL match_state got %0h want 2", disp_state); else pass_cnt++;
        total_cnt++; if (ens !== 5'b00101) $display("FAIL match_ens got %b want 00101", ens); else pass_cnt++;
        // Debounce: short low run, one high, then full run
        hall = 0;
        for (int i = 0; i < TB_DEB - 1; i++) tick();
        hall = 1; tick();
        total_cnt++; if (disp_state !== 4'h2) $display("FAIL deb_after_glitch got %0h want 2", disp_state); else pass_cnt++;
        hall = 0;
        for (int i = 0; i < TB_DEB - 1; i++) tick();
        total_cnt++; if (disp_state !== 4'h2) $display("FAIL deb_one_short got %0h want 2", disp_state); else pass_cnt++;
        tick(); hall = 1;
        total_cnt++; if (disp_state !== 4'h4) $display("FAIL deb_uturn got %0h want 4", disp_state); else pass_cnt++;
        total_cnt++; if (ens !== 5'b01000) $display("FAIL uturn_ens got %b want 01000", ens); else pass_cnt++;
        uturn_finished = 1; tick(); uturn_finished = 0;
        total_cnt++; if ({disp_state, ens} !== {4'h5, 5'b10000}) $display("FAIL return_state got %0h/%b want 5/10000", disp_state, ens); else pass_cnt++;
        end_of_track = 1; tick(); end_of_track = 0;
        total_cnt++; if (disp_state !== 4'h4) $display("FAIL home_uturn got %0h want 4", disp_state); else pass_cnt++;
        uturn_finished = 1; tick(); uturn_finished = 0;
        total_cnt++; if ({disp_state, ens} !== {4'h6, 5'b00010}) $display("FAIL reverse_state got %0h/%b want 6/00010", disp_state, ens); else pass_cnt++;
        reverse_finished = 1; tick(); reverse_finished = 0;
        total_cnt++; if ({disp_state, disp_color, object_led} !== {4'h0, 2'd0, 1'b1}) $display("FAIL match_home got %0h/%0d/%b want 0/0/1", disp_state, disp_color, object_led); else pass_cnt++;
    endtask

    task automatic test_nocolor();
        start = 1; object_color = 0; tick(); start = 0;
        total_cnt++; if ({disp_state, ens} !== {4'h7, 5'b00001}) $display("FAIL nocolor_state got %0h/%b want 7/00001", disp_state, ens); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (disp_state !== 4'h7) $display("FAIL nocolor_hold got %0h want 7", disp_state); else pass_cnt++;
        buzz_finished = 1; tick(); buzz_finished = 0;
        total_cnt++; if ({disp_state, object_led, ens} !== {4'h0, 1'b1, 5'b00000}) $display("FAIL nocolor_ready got %0h/%b/%b want 0/1/00000", disp_state, object_led, ens); else pass_cnt++;
    endtask

    task automatic test_laps();
        start = 1; object_color = 3; station_color = 1; tick(); start = 0;
        // start ignored outside READY
        start = 1; object_color = 1; tick(); start = 0; object_color = 0;
        total_cnt++; if ({disp_state, disp_color} !== {4'h1, 2'd3}) $display("FAIL laps_start_ignored got %0h/%0d want 1/3", disp_state, disp_color); else pass_cnt++;
        end_of_track = 1; tick(); end_of_track = 0;
        total_cnt++; if ({disp_state, lap_cnt, ens} !== {4'h3, 2'd1, 5'b00101}) $display("FAIL laps_eot1 got %0h/%0d/%b want 3/1/00101", disp_state, lap_cnt, ens); else pass_cnt++;
        buzz_finished = 1; tick(); buzz_finished = 0; tick();
        total_cnt++; if (disp_state !== 4'h3) $display("FAIL laps_buzz_only got %0h want 3", disp_state); else pass_cnt++;
        brake_finished = 1; tick(); brake_finished = 0;
        total_cnt++; if (disp_state !== 4'h4) $display("FAIL laps_sticky_uturn got %0h want 4", disp_state); else pass_cnt++;
        uturn_finished = 1; tick(); uturn_finished = 0;
        total_cnt++; if ({disp_state, lap_cnt} !== {4'h1, 2'd1}) $display("FAIL laps_resend got %0h/%0d want 1/1", disp_state, lap_cnt); else pass_cnt++;
        end_of_track = 1; tick(); end_of_track = 0;
        total_cnt++; if ({disp_state, lap_cnt} !== {4'h3, 2'd2}) $display("FAIL laps_eot2 got %0h/%0d want 3/2", disp_state, lap_cnt); else pass_cnt++;
        buzz_finished = 1; brake_finished = 1; tick(); buzz_finished = 0; brake_finished = 0;
        total_cnt++; if (disp_state !== 4'h4) $display("FAIL laps_giveup_uturn got %0h want 4", disp_state); else pass_cnt++;
        uturn_finished = 1; tick(); uturn_finished = 0;
        total_cnt++; if (disp_state !== 4'h5) $display("FAIL laps_return got %0h want 5", disp_state); else pass_cnt++;
        end_of_track = 1; tick(); end_of_track = 0;
        uturn_finished = 1; tick(); uturn_finished = 0;
        total_cnt++; if (disp_state !== 4'h6) $display("FAIL laps_reverse got %0h want 6", disp_state); else pass_cnt++;
        reverse_finished = 1; tick(); reverse_finished = 0;
        total_cnt++; if ({disp_state, lap_cnt, disp_color} !== {4'h0, 2'd0, 2'd0}) $display("FAIL laps_ready got %0h/%0d/%0d want 0/0/0", disp_state, lap_cnt, disp_color); else pass_cnt++;
    endtask

    task automatic test_match_vs_eot();
        start = 1; object_color = 1; station_color = 0; tick(); start = 0;
        station_color = 1; end_of_track = 1; tick(); end_of_track = 0;
        total_cnt++; if ({disp_state, lap_cnt} !== {4'h2, 2'd0}) $display("FAIL prio_match got %0h/%0d want 2/0", disp_state, lap_cnt); else pass_cnt++;
        // Reset mid-trip
        rst = 0; tick(); rst = 1;
        total_cnt++; if ({disp_state, ens, disp_color, object_led} !== {4'h0, 5'b00000, 2'd0, 1'b1}) $display("FAIL midtrip_reset got %0h/%b/%0d/%b want 0/00000/0/1", disp_state, ens, disp_color, object_led); else pass_cnt++;
        idle_inputs(); tick();
    endtask

`ifdef DELIVERY_WDOG_EN
    task automatic test_watchdog();
        start = 1; object_color = 2; station_color = 0; tick(); start = 0;
        for (int i = 0; i < TB_WDOG - 1; i++) tick();
        total_cnt++; if ({disp_state, fault} !== {4'h1, 1'b0}) $display("FAIL wdog_before got %0h/%b want 1/0", disp_state, fault); else pass_cnt++;
        tick();
        total_cnt++; if ({disp_state, fault, ens} !== {4'hF, 1'b1, 5'b00001}) $display("FAIL wdog_fault got %0h/%b/%b want f/1/00001", disp_state, fault, ens); else pass_cnt++;
        rst = 0; tick(); rst = 1;
        total_cnt++; if ({disp_state, fault} !== {4'h0, 1'b0}) $display("FAIL wdog_reset got %0h/%b want 0/0", disp_state, fault); else pass_cnt++;
    endtask
`endif

    // Sequence and final report
    initial begin
        test_reset();
        test_match();
        test_nocolor();
        test_laps();
        test_match_vs_eot();
`ifdef DELIVERY_WDOG_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
